// File: rtl/bank_xbar_rtn_arb.sv
// Round-robin return arbiter: shares one xbar return port between NUM_BANK bank SRAM controllers,
// gated by per-channel credits, with a registered output beat. Optional macro: BANK_XBAR_RTN_ARB_PERF_EN.
module bank_xbar_rtn_arb #(
    parameter int NUM_BANK   = 4,
    parameter int DATA_W     = 128,
    parameter int CREDIT_MAX = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_BANK-1:0]         bank_xbar_valid_i,
    output logic [NUM_BANK-1:0]         bank_xbar_ready_o,
    input  logic [2*NUM_BANK-1:0]       bank_xbar_ch_id_i,
    input  logic [3*NUM_BANK-1:0]       bank_xbar_rob_num_i,
    input  logic [DATA_W*NUM_BANK-1:0]  bank_xbar_data_i,
    output logic                        xbar_rtn_valid_o,
    input  logic                        xbar_rtn_ready_i,
    output logic [1:0]                  xbar_rtn_ch_id_o,
    output logic [2:0]                  xbar_rtn_rob_num_o,
    output logic [$clog2(NUM_BANK)-1:0] xbar_rtn_bank_id_o,
    output logic [DATA_W-1:0]           xbar_rtn_data_o,
    input  logic [2:0]                  xbar_credit_rtn_i,
    output logic                        arb_err_o,
    output logic [15:0]                 perf_stall_cnt_o
);
    localparam int              BW          = $clog2(NUM_BANK);
    localparam int              NUM_CH      = 3;
    localparam logic [3:0]      CREDIT_FULL = 4'(CREDIT_MAX);
    localparam logic [BW-1:0]   LAST_BANK   = BW'(NUM_BANK - 1);

    // Registered state
    logic [BW-1:0]     r_rr_ptr;
    logic [3:0]        r_credit [NUM_CH];
    logic              r_out_valid;
    logic [1:0]        r_out_ch;
    logic [2:0]        r_out_rob;
    logic [BW-1:0]     r_out_bank;
    logic [DATA_W-1:0] r_out_data;
    logic              r_err;

    // Combinational decode
    logic [1:0]          w_ch [NUM_BANK];
    logic [NUM_BANK-1:0] w_legal;
    logic [NUM_BANK-1:0] w_elig;
    logic [3:0]          w_has_credit;
    logic                w_ch3_req;
    logic                w_gnt_found;
    logic [BW-1:0]       w_gnt_idx;
    logic                w_slot_free;
    logic                w_grant;
    logic [1:0]          w_sel_ch;
    logic [2:0]          w_sel_rob;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_CH-1:0]   w_cr_inc;
    logic [NUM_CH-1:0]   w_cr_dec;
    logic                w_overflow;

    // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        w_has_credit = 4'b0000;
        for (int c = 0; c < NUM_CH; c++) begin
            w_has_credit[c] = (r_credit[c] != 4'd0);
        end
        w_ch3_req = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_ch[b]    = bank_xbar_ch_id_i[2*b +: 2];
            w_legal[b] = bank_xbar_valid_i[b] && (w_ch[b] != 2'd3);
            // Channel 3 has no credit counter, so w_has_credit[3] stays 0 and it is never eligible.
            w_elig[b]  = w_legal[b] && w_has_credit[w_ch[b]];
            w_ch3_req  = w_ch3_req | (bank_xbar_valid_i[b] && (w_ch[b] == 2'd3));
        end
    end

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < NUM_BANK; k++) begin
            if (!w_gnt_found && w_elig[(int'(r_rr_ptr) + k) % NUM_BANK]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = BW'((int'(r_rr_ptr) + k) % NUM_BANK);
            end
        end
    end

    assign w_slot_free       = !r_out_valid || xbar_rtn_ready_i;
    assign w_grant           = rst_i && w_slot_free && w_gnt_found;
    assign bank_xbar_ready_o = w_grant ? (NUM_BANK'(1) << w_gnt_idx) : '0;

    assign w_sel_ch   = bank_xbar_ch_id_i[2*int'(w_gnt_idx) +: 2];
    assign w_sel_rob  = bank_xbar_rob_num_i[3*int'(w_gnt_idx) +: 3];
    assign w_sel_data = bank_xbar_data_i[DATA_W*int'(w_gnt_idx) +: DATA_W];

    // A return that coincides with a grant on the same channel nets to zero and is never an overflow.
    always_comb begin
        w_cr_inc   = xbar_credit_rtn_i;
        w_cr_dec   = '0;
        w_overflow = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_cr_dec[c] = w_grant && (w_sel_ch == 2'(c));
            w_overflow  = w_overflow
                        | (w_cr_inc[c] && !w_cr_dec[c] && (r_credit[c] == CREDIT_FULL));
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_credit[c] <= CREDIT_FULL;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_cr_inc[c] && !w_cr_dec[c]) begin
                    if (r_credit[c] != CREDIT_FULL) begin
                        r_credit[c] <= r_credit[c] + 4'd1;
                    end
                end else if (w_cr_dec[c] && !w_cr_inc[c]) begin
                    r_credit[c] <= r_credit[c] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_gnt_idx == LAST_BANK) ? '0 : w_gnt_idx + 1'b1;
            end
            r_err <= r_err | w_overflow | w_ch3_req;
        end
    end

    // NOTE: the payload flops are reset as well because their zero reset value is visible on the port.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_rob   <= '0;
            r_out_bank  <= '0;
            r_out_data  <= '0;
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= w_sel_ch;
            r_out_rob   <= w_sel_rob;
            r_out_bank  <= w_gnt_idx;
            r_out_data  <= w_sel_data;
        end else if (xbar_rtn_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign xbar_rtn_valid_o   = r_out_valid;
    assign xbar_rtn_ch_id_o   = r_out_ch;
    assign xbar_rtn_rob_num_o = r_out_rob;
    assign xbar_rtn_bank_id_o = r_out_bank;
    assign xbar_rtn_data_o    = r_out_data;
    assign arb_err_o          = r_err;

`ifdef BANK_XBAR_RTN_ARB_PERF_EN
    logic [15:0] r_perf_cnt;
    logic        w_credit_stall;

    // Some legal request is waiting and none is eligible: the only blocker is zero credit.
    assign w_credit_stall = (|w_legal) && !(|w_elig);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_perf_cnt <= 16'h0000;
        end else if (w_credit_stall && (r_perf_cnt != 16'hFFFF)) begin
            r_perf_cnt <= r_perf_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt_o = r_perf_cnt;
`else
    assign perf_stall_cnt_o = 16'h0000;
`endif

endmodule
